// File: rtl/md5_chunk_feeder_if.sv
// md5_chunk_feeder_if: byte stream, cruncher control and word read port of the MD5 chunk feeder
interface md5_chunk_feeder_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic crunch_init;
  logic crunch_start;
  logic crunch_done;
  logic [3:0] gaddr;
  logic [31:0] mdata;
  logic digest_valid;
  modport slave (
    input in_data, in_valid, in_last, crunch_done, gaddr,
    output in_ready, crunch_init, crunch_start, mdata, digest_valid
  );
  modport master (
    output in_data, in_valid, in_last, crunch_done, gaddr,
    input in_ready, crunch_init, crunch_start, mdata, digest_valid
  );
endinterface

// File: rtl/md5_chunk_feeder.sv
// md5_chunk_feeder: packs a byte stream into 16-word MD5 chunks with padding and sequences the cruncher
module md5_chunk_feeder #(
  parameter int LEN_BYTES_W = 61
) (
  input logic clk,
  input logic reset_n,
  md5_chunk_feeder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FILL, PAD, ZERO, LEN, START, WAIT} state_t;
  state_t state, state_n, ret, ret_n;
  logic [31:0] mem [16];
  logic [5:0] ptr, ptr_n;
  logic [LEN_BYTES_W-1:0] byte_cnt;
  logic marker_done, digest_valid;
  logic wr_en, len_wr, cnt_clr, cnt_inc, mk_set, dv_set, rdy, init, start;
  logic [7:0] wr_val;
  logic [63:0] bitlen;
  assign bitlen = 64'({byte_cnt, 3'b000});
  assign bus.mdata = mem[bus.gaddr];
  assign bus.in_ready = rdy;
  assign bus.crunch_init = init & reset_n;
  assign bus.crunch_start = start;
  assign bus.digest_valid = digest_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ret <= IDLE;
    end else begin
      state <= state_n;
      ret <= ret_n;
    end
  // ret == IDLE marks the length chunk: its done completes the digest
  always_comb begin
    state_n = state;
    ret_n = ret;
    ptr_n = ptr;
    wr_en = 1'b0;
    wr_val = bus.in_data;
    len_wr = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    mk_set = 1'b0;
    dv_set = 1'b0;
    rdy = 1'b0;
    init = 1'b0;
    start = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        init = 1'b1;
        cnt_clr = 1'b1;
        ptr_n = 6'd0;
        state_n = FILL;
      end
      FILL: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          wr_en = 1'b1;
          cnt_inc = 1'b1;
          ptr_n = ptr + 6'd1;
          state_n = (ptr == 6'd63) ? START : bus.in_last ? PAD : FILL;
          ret_n = (ptr == 6'd63) ? (bus.in_last ? PAD : FILL) : ret;
        end
      end
      PAD, ZERO: begin
        wr_en = 1'b1;
        wr_val = (state == PAD && !marker_done) ? 8'h80 : 8'h00;
        mk_set = state == PAD;
        ptr_n = ptr + 6'd1;
        state_n = (ptr == 6'd55) ? LEN : (ptr == 6'd63) ? START : ZERO;
        ret_n = ZERO;
      end
      LEN: begin
        len_wr = 1'b1;
        state_n = START;
        ret_n = IDLE;
      end
      START: begin
        start = 1'b1;
        state_n = WAIT;
      end
      WAIT: if (bus.crunch_done) begin
        ptr_n = 6'd0;
        dv_set = ret == IDLE;
        state_n = ret;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem <= '{default: '0};
      ptr <= '0;
      byte_cnt <= '0;
      marker_done <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      ptr <= ptr_n;
      byte_cnt <= cnt_clr ? '0 : cnt_inc ? byte_cnt + LEN_BYTES_W'(1) : byte_cnt;
      marker_done <= !cnt_clr && (marker_done || mk_set);
      digest_valid <= dv_set || (digest_valid && !init);
      if (wr_en) mem[ptr[5:2]][{ptr[1:0], 3'b000} +: 8] <= wr_val;
      if (len_wr) begin
        mem[14] <= bitlen[31:0];
        mem[15] <= bitlen[63:32];
      end
    end
endmodule

// File: tb/tb_md5_chunk_feeder.sv
// tb_md5_chunk_feeder: random message streams against a byte-level MD5 padding model
module tb_md5_chunk_feeder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  md5_chunk_feeder_if bus();
  md5_chunk_feeder #(.LEN_BYTES_W(61)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #50 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] msg_q[$];
  logic [31:0] exp_w[$], got_w[$];
  int n_starts, n_inits, n_acc, init_cyc, first_acc, rdy_busy, acc_busy, buf_chg, dv_cyc, done_cyc, dv_post, timeout;

  task automatic build_model();
    logic [7:0] p[$];
    logic [63:0] bl;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg_q.size()) << 3;
    for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
    exp_w.delete();
    for (int i = 0; i < p.size(); i += 4) exp_w.push_back({p[i+3], p[i+2], p[i+1], p[i]});
  endtask

  task automatic read_words(output logic [31:0] w[16]);
    for (int g = 0; g < 16; g++) begin
      bus.gaddr = 4'(g);
      #1;
      w[g] = bus.mdata;
    end
  endtask

  task automatic rand_msg(input int len, input bit zeros);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(zeros ? 8'h00 : 8'($urandom));
  endtask

  task automatic run_msg(input int stall, input int gap, input bit abort);
    int idx = 0, dcnt = 0, cyc = 0, wait_cyc = 0;
    bit busy = 0, seen_init = 0, hold = 0;
    logic [31:0] snap[16], now[16];
    n_starts = 0; n_inits = 0; n_acc = 0; rdy_busy = 0; acc_busy = 0; buf_chg = 0; timeout = 0;
    init_cyc = -1; first_acc = -1; dv_cyc = -1; done_cyc = -1; dv_post = -1;
    got_w.delete();
    build_model();
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin
        timeout = 1;
        bus.in_valid = 1'b0;
        return;
      end
      if (busy) begin
        wait_cyc++;
        if (abort && wait_cyc == 5) return;
        if (dcnt == 0) begin
          read_words(now);
          foreach (now[g]) if (now[g] !== snap[g]) buf_chg++;
          bus.crunch_done = 1'b1;
          busy = 0;
          done_cyc = cyc;
        end else dcnt--;
      end
      if (!hold) bus.in_valid = (idx < msg_q.size()) && (int'($urandom_range(0, 99)) >= gap);
      if (idx < msg_q.size()) begin
        bus.in_data = msg_q[idx];
        bus.in_last = idx == msg_q.size() - 1;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_data = 8'($urandom);
      end
      #1;
      hold = bus.in_valid && !bus.in_ready;
      if (bus.in_valid && bus.in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        if (busy) acc_busy++;
        n_acc++;
        idx++;
      end
      if (busy && bus.in_ready) rdy_busy++;
      if (bus.crunch_init) begin
        n_inits++;
        init_cyc = cyc;
        seen_init = 1;
      end
      if (seen_init && cyc == init_cyc + 1) dv_post = int'(bus.digest_valid);
      if (bus.crunch_start) begin
        n_starts++;
        bus.crunch_done = 1'b0;
        read_words(snap);
        foreach (snap[g]) got_w.push_back(snap[g]);
        busy = 1;
        wait_cyc = 0;
        dcnt = (n_starts == 1) ? stall : int'($urandom_range(0, 4));
      end
      if (seen_init && cyc > init_cyc && bus.digest_valid && idx == msg_q.size()) begin
        dv_cyc = cyc;
        bus.in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] w[16];
    int bad = 0;
    reset_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.crunch_init !== 1'b0) begin errors++; $display("FAIL reset_init: got %b expected 0", bus.crunch_init); end
    checks++; if (bus.crunch_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus.crunch_start); end
    checks++; if (bus.digest_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", bus.digest_valid); end
    read_words(w);
    foreach (w[g]) if (w[g] !== 32'h0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_mdata: got %0d nonzero words expected 0", bad); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_abc();
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(2, 0, 0);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL abc_timeout: got %0d expected 0", timeout); end
    checks++; if (n_starts !== 1) begin errors++; $display("FAIL abc_starts: got %0d expected 1", n_starts); end
    checks++; if (n_inits !== 1) begin errors++; $display("FAIL abc_inits: got %0d expected 1", n_inits); end
    checks++; if (first_acc !== init_cyc + 1) begin errors++; $display("FAIL abc_latency: got %0d expected %0d", first_acc, init_cyc + 1); end
    checks++; if (dv_cyc !== done_cyc + 1) begin errors++; $display("FAIL abc_dv_rise: got %0d expected %0d", dv_cyc, done_cyc + 1); end
    checks++; if (got_w.size() !== 16) begin errors++; $display("FAIL abc_words: got %0d expected 16", got_w.size()); end
    else begin
      checks++; if (got_w[0] !== 32'h80636261) begin errors++; $display("FAIL abc_w0: got %h expected 80636261", got_w[0]); end
      checks++; if (got_w[14] !== 32'h00000018) begin errors++; $display("FAIL abc_w14: got %h expected 00000018", got_w[14]); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (got_w[i] !== exp_w[i]) begin errors++; $display("FAIL abc_word%0d: got %h expected %h", i, got_w[i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_boundaries();
    int lens[6] = '{55, 56, 63, 64, 119, 120};
    foreach (lens[k]) begin
      rand_msg(lens[k], lens[k] == 55);
      run_msg(1, 20, 0);
      checks++; if (timeout !== 0 || got_w.size() !== exp_w.size()) begin errors++; $display("FAIL bnd%0d_words: got %0d expected %0d", lens[k], got_w.size(), exp_w.size()); end
      else begin
        for (int i = 0; i < exp_w.size(); i++) begin
          checks++; if (got_w[i] !== exp_w[i]) begin errors++; $display("FAIL bnd%0d_word%0d: got %h expected %h", lens[k], i, got_w[i], exp_w[i]); end
        end
        if (lens[k] == 55) begin
          checks++; if (got_w[13] !== 32'h80000000 || got_w[14] !== 32'h000001B8) begin errors++; $display("FAIL bnd55_pad: got %h %h expected 80000000 000001b8", got_w[13], got_w[14]); end
        end
        if (lens[k] == 56) begin
          checks++; if (got_w[14] !== 32'h00000080 || got_w[30] !== 32'h000001C0) begin errors++; $display("FAIL bnd56_pad: got %h %h expected 00000080 000001c0", got_w[14], got_w[30]); end
        end
        if (lens[k] == 64) begin
          checks++; if (got_w[16] !== 32'h00000080 || got_w[30] !== 32'h00000200) begin errors++; $display("FAIL bnd64_pad: got %h %h expected 00000080 00000200", got_w[16], got_w[30]); end
        end
      end
      checks++; if (rdy_busy !== 0) begin errors++; $display("FAIL bnd%0d_ready_in_wait: got %0d expected 0", lens[k], rdy_busy); end
    end
  endtask

  task automatic test_backpressure();
    rand_msg(74, 0);
    run_msg(100, 0, 0);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL bp_timeout: got %0d expected 0", timeout); end
    checks++; if (rdy_busy !== 0) begin errors++; $display("FAIL bp_ready: got %0d ready cycles expected 0", rdy_busy); end
    checks++; if (acc_busy !== 0) begin errors++; $display("FAIL bp_accept: got %0d expected 0", acc_busy); end
    checks++; if (buf_chg !== 0) begin errors++; $display("FAIL bp_buffer: got %0d changed words expected 0", buf_chg); end
    checks++; if (n_acc !== 74) begin errors++; $display("FAIL bp_count: got %0d expected 74", n_acc); end
    checks++; if (got_w !== exp_w) begin errors++; $display("FAIL bp_words: got %0d words expected %0d matching", got_w.size(), exp_w.size()); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      rand_msg(int'($urandom_range(1, 150)), 0);
      run_msg(int'($urandom_range(0, 6)), 30, 0);
      checks++; if (timeout !== 0 || n_acc !== msg_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", r, n_acc, msg_q.size()); end
      checks++; if (got_w !== exp_w) begin errors++; $display("FAIL rnd%0d_words: got %0d words expected %0d matching", r, got_w.size(), exp_w.size()); end
      checks++; if (n_starts !== exp_w.size() / 16) begin errors++; $display("FAIL rnd%0d_starts: got %0d expected %0d", r, n_starts, exp_w.size() / 16); end
      checks++; if (first_acc !== init_cyc + 1 || n_inits !== 1) begin errors++; $display("FAIL rnd%0d_init: got %0d/%0d expected %0d/1", r, first_acc, n_inits, init_cyc + 1); end
    end
  endtask

  task automatic test_back_to_back();
    rand_msg(10, 0);
    run_msg(0, 0, 0);
    rand_msg(70, 0);
    run_msg(0, 0, 0);
    checks++; if (dv_post !== 0) begin errors++; $display("FAIL b2b_dv_clear: got %0d expected 0", dv_post); end
    checks++; if (dv_cyc !== done_cyc + 1) begin errors++; $display("FAIL b2b_dv_rise: got %0d expected %0d", dv_cyc, done_cyc + 1); end
    checks++; if (got_w !== exp_w) begin errors++; $display("FAIL b2b_words: got %0d words expected %0d matching", got_w.size(), exp_w.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[16];
    int bad = 0;
    rand_msg(100, 0);
    run_msg(100, 0, 1);
    checks++; if (n_starts !== 1) begin errors++; $display("FAIL rmid_reach_wait: got %0d starts expected 1", n_starts); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({bus.in_ready, bus.crunch_init, bus.crunch_start, bus.digest_valid} !== 4'b0) begin errors++; $display("FAIL rmid_outputs: got %b expected 0000", {bus.in_ready, bus.crunch_init, bus.crunch_start, bus.digest_valid}); end
    read_words(w);
    foreach (w[g]) if (w[g] !== 32'h0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_mdata: got %0d nonzero words expected 0", bad); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(3, 0, 0);
    checks++; if (timeout !== 0 || n_inits !== 1 || n_starts !== 1) begin errors++; $display("FAIL rmid_abc_seq: got %0d/%0d/%0d expected 0/1/1", timeout, n_inits, n_starts); end
    checks++; if (got_w !== exp_w) begin errors++; $display("FAIL rmid_abc_words: got %0d words expected %0d matching", got_w.size(), exp_w.size()); end
  endtask

  initial begin
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.crunch_done = 1'b0;
    bus.gaddr = 4'd0;
    test_reset();
    test_abc();
    test_boundaries();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/md5_chunk_feeder.md
# md5_chunk_feeder

Byte-stream front end for the MD5 chunk cruncher. It packs an incoming message into a 16-word chunk buffer and applies MD5 padding: a 0x80 marker, zero fill, and the 64-bit little-endian bit length. It serves message words to the cruncher through the cruncher's `gaddr`/`mdata` read port and sequences one `start`/`done` exchange per chunk. It also re-initialises the cruncher's chaining state at the start of each message and flags when the cruncher's digest is final.

## Interface

Parameters:
- `LEN_BYTES_W`, default 61: width of the message byte counter. Bit length is `{byte_cnt, 3'b000}`, truncated or zero-extended to 64 bits.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  qualifies the final byte of a message; only meaningful when `in_valid`=1.
- `in_ready`  out  1  byte accepted on a cycle where `in_valid` and `in_ready` are both 1.
- `crunch_init`  out  1  one-cycle pulse; drives the cruncher's synchronous `reset` to load the initial A/B/C/D.
- `crunch_start`  out  1  one-cycle pulse; drives the cruncher's `start`.
- `crunch_done`  in  1  the cruncher's `done` level.
- `gaddr`  in  4  word index requested by the cruncher.
- `mdata`  out  32  buffer word `gaddr`, combinational, zero latency.
- `digest_valid`  out  1  level; the cruncher `digest` is the final MD5 of the last message.

## Operation

- **Buffer:** 16×32 registers.
  - Byte position p (0..63) maps to `buf[p>>2][8*(p%4)+:8]` (little-endian packing).
  - `mdata = buf[gaddr]`.
  - The buffer is not written from the `crunch_start` cycle until `crunch_done` is sampled high.
- **Counters:**
  - `ptr` (6 bits) is the byte position and wraps 63→0.
  - `byte_cnt` (`LEN_BYTES_W` bits) counts accepted bytes and is cleared on message start.
  - `marker_done` flag records that 0x80 has been written.
- **States:**
  - **IDLE:** `in_ready`=0. When `in_valid`=1: pulse `crunch_init`, clear `digest_valid`, `byte_cnt`, `ptr` and `marker_done`, then go to FILL. The byte is not consumed in IDLE.
  - **FILL:** `in_ready`=1. On each accepted byte, write it at `ptr`, increment `ptr` and `byte_cnt`.
    - `ptr`=63 and not last → START, with `ret`=FILL.
    - Last and `ptr`=63 → START, with `ret`=PAD.
    - Last and `ptr`<63 → PAD.
  - **PAD:** `in_ready`=0. Write 0x80 at `ptr`, set `marker_done`.
    - Old `ptr`≤55 → ZERO.
    - Otherwise → ZERO, filling to 63 and then START with `ret`=ZERO.
  - **ZERO:** write 0x00 at `ptr`, one byte per cycle.
    - Stop after byte 55 → LEN.
    - If the marker sat above 55, stop after byte 63 → START with `ret`=ZERO; the next chunk then zeros 0..55.
  - **LEN:** in one cycle, write `buf[14]` = bitlen[31:0] and `buf[15]` = bitlen[63:32], then → START with `ret`=FINAL.
  - **START:** `crunch_start`=1 for exactly one cycle → WAIT.
  - **WAIT:** hold until `crunch_done`=1.
    - `ret`=FINAL → IDLE, set `digest_valid`.
    - Otherwise → `ret`, with `ptr`=0.
- **Arithmetic:**
  - `byte_cnt` wraps modulo 2^`LEN_BYTES_W`.
  - bitlen wraps modulo 2^64.
  - An empty message is not supported: every message has at least one byte carrying `in_last`.
- **Reset (any state, mid-message included):**
  - State → IDLE.
  - All buffer words = 0, counters = 0, `digest_valid`=0.
  - The partial message is discarded. The cruncher gets `crunch_init` on the next message.

## Timing

- Reset values:
  - `in_ready`=0, `crunch_init`=0, `crunch_start`=0, `digest_valid`=0.
  - `mdata`=0 for any `gaddr`.
- Throughput is one byte per cycle in FILL and one pad byte per cycle in PAD/ZERO.
- The LEN→START→WAIT sequence takes 2 cycles before the cruncher runs.
- `crunch_done` is evaluated only from the cycle after `crunch_start`. The cruncher drops `done` at that edge, so a stale high is never seen.
- Latency from IDLE with `in_valid`: `crunch_init` in cycle 0, first byte accepted in cycle 1.
- `digest_valid` rises the cycle after the final `crunch_done` is sampled. It stays high until the next message's `crunch_init` cycle.
- If `in_valid` is held during PAD/ZERO/LEN/START/WAIT, nothing is consumed, nothing is lost, and the upstream holds its data.

## Test plan

- Reset, then send "abc" (0x61, 0x62, 0x63 with `in_last`):
  - Exactly one `crunch_start`.
  - `mdata`: word0=0x80636261, words 1..13=0, word14=0x00000018, word15=0.
  - With the real cruncher, the digest equals MD5("abc") = 900150983cd24fb0d6963f7de28e17f2, and `digest_valid`=1.
- 55-byte message of 0x00:
  - One chunk; word13=0x80000000, word14=0x000001B8.
- 56-byte message:
  - Two chunks. Chunk 1 word14=0x00000080.
  - Chunk 2 words 0..13=0, word14=0x000001C0.
- 64-byte message:
  - Two chunks; chunk 2 word0=0x00000080, word14=0x00000200.
  - `in_ready` is low from byte 64 acceptance until after chunk 1's `done`.
- Backpressure: `in_valid` held high, cruncher stalled (`crunch_done` low for 100 cycles during WAIT):
  - `in_ready`=0 throughout and buffer words unchanged.
  - After `done`, the byte stream resumes with no loss or duplication; `byte_cnt` matches the bytes sent.
- `reset_n` pulsed low during WAIT of a 2-chunk message:
  - All outputs go to their reset values immediately.
  - A following "abc" message produces the correct digest.
